mem_traffic_checker: RTL
========================

// Module: mem_traffic_checker
// PURPOSE
//  Parametrised write-then-read-back traffic generator/checker for one DDR2 user port.
//  Writes NUM_XFER pseudo-random bursts to BASE_ADDR + i*ADDR_STRIDE, reads them back and compares.
//  Optionally loops forever.
//  Sits in place of a cache master on the memory-controller user port for board/bring-up test.
// PARAMETERS
//  DATA_W         256          data bus width; multiple of 32
//  ADDR_W         28           address bus width
//  NUM_XFER       9            transfers per phase, 1..65535
//  BASE_ADDR      28'h3000000  address of transfer 0
//  ADDR_STRIDE    8            address increment per transfer; wraps modulo 2^ADDR_W
//  GAP_CYCLES     50           idle cycles with mem_valid low after each handshake; 0 = back-to-back
//  SEED           32'hACE1_2468  LFSR seed; must be nonzero
//  TIMEOUT_CYCLES 4096         watchdog limit, used only with MEM_TC_TIMEOUT_EN
// PORTS
//  clk         in   1       clock
//  rst         in   1       synchronous, active-high reset
//  start       in   1       one-cycle pulse; begins a run from IDLE; ignored otherwise
//  loop_en     in   1       sampled at start; 1 = repeat write+read passes until rst
//  mem_data_wr out  DATA_W  write data
//  mem_data_rd in   DATA_W  read data, valid in the handshake cycle of a read
//  mem_addr    out  ADDR_W  transfer address
//  mem_rw      out  1       1 = write, 0 = read
//  mem_valid   out  1       command valid
//  mem_ready   in   1       controller accepts/completes command
//  busy        out  1       high in any state except IDLE/DONE
//  done        out  1       high in DONE; cleared by start
//  error       out  1       sticky: any read miscompare (or timeout) since start
//  err_count   out  16      miscompare count, saturates at 16'hFFFF
//  fail_addr   out  ADDR_W  address of the first miscompare
//  pass_count  out  16      completed write+read passes, wraps
// BEHAVIOUR
//  Reset: all outputs 0, mem_data_wr 0, state IDLE.
//  Reset mid-run aborts immediately; no further mem_valid.
//  FSM: IDLE -start-> WR_REQ.
//   WR_REQ -hs-> WR_GAP, or RD_REQ on the last write when GAP_CYCLES=0.
//   WR_GAP -gap done-> WR_REQ, or RD_REQ after the last write.
//   RD_REQ/RD_GAP behave the same way.
//   After the last read: pass_count+1, then WR_REQ if loop latched, else DONE.
//   DONE -start-> WR_REQ; start clears error, err_count, fail_addr, pass_count.
//  Handshake (hs) = mem_valid & mem_ready at a posedge.
//   mem_valid is high only in *_REQ.
//   addr/rw/wdata are stable while valid && !ready.
//   GAP_CYCLES=0: the next command is presented the cycle after hs, with valid held high.
//  Gap: exactly GAP_CYCLES cycles with valid low between hs and the next valid.
//  Index i counts 0..NUM_XFER-1 per phase and resets to 0 at each phase start.
//   mem_addr = BASE_ADDR + i*ADDR_STRIDE, truncated to ADDR_W.
//  Data: 32-bit Galois LFSR, poly 0x80200003, reloaded with SEED at each phase start and stepped on each hs.
//   Lane k (bits 32k+31:32k) = lfsr ^ k.
//   Read expect = same sequence, so both phases match.
//  Compare on a read hs: if mem_data_rd != expect, then:
//   error <= 1; err_count +1 (saturating);
//   fail_addr <= mem_addr, on the first miscompare only.
//  start while busy: ignored.
//  mem_ready while valid is low: ignored.
// CONFIGURATION
//  MEM_TC_TIMEOUT_EN defined: a counter runs while mem_valid & !mem_ready.
//   On reaching TIMEOUT_CYCLES: error <= 1, valid dropped, state -> DONE; err_count unchanged.
//   Counter clears on hs.
//  MEM_TC_TIMEOUT_EN undefined: no watchdog; the block waits indefinitely for mem_ready.
// STRUCTURE
//  mem_tc_pkg: state enum, LFSR_POLY constant, lane-expand function.
//  Sub-module mem_tc_lfsr32: load/step ports, 32-bit state out.
//   One instance serves both phases because it is reloaded at each phase start.
// TESTING
//  1. NUM_XFER=9, GAP=50, ideal memory model, ready 1 cycle after valid, start:
//     -> 9 writes then 9 reads; done=1, error=0, pass_count=1; every gap exactly 50 cycles.
//  2. Same as 1, but the model flips bit 0 of read index 3:
//     -> error=1, err_count=1, fail_addr=28'h3000018.
//  3. GAP=0, ready held high:
//     -> valid high for 18 consecutive cycles with one transfer per cycle; rw falls after the 9th.
//  4. loop_en=1, random ready stalls 0..20 cycles:
//     -> pass_count increments every pass, error stays 0, addr/data held during stalls.
//  5. rst asserted during a read stall:
//     -> next cycle all outputs 0 and state IDLE; a new start restarts from transfer 0.
//  6. MEM_TC_TIMEOUT_EN, TIMEOUT_CYCLES=100, ready never asserted:
//     -> error=1 and done=1 at 100 cycles after valid rose, valid=0.

Source files
------------

// File: rtl/mem_tc_pkg.sv
// Shared state encoding, LFSR polynomial and data-lane helper for the memory traffic checker.
package mem_tc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_GAP,
    ST_RD_REQ,
    ST_RD_GAP,
    ST_DONE
  } mem_tc_state_e;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Each 32-bit lane carries the LFSR word XORed with its lane number.
  function automatic logic [31:0] lane_word(input logic [31:0] lfsr, input int lane);
    return lfsr ^ 32'(lane);
  endfunction

endpackage

// File: rtl/mem_tc_lfsr32.sv
// 32-bit Galois LFSR (right-shifting, LFSR_POLY tap mask); load has priority over step.
module mem_tc_lfsr32
  import mem_tc_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        step_i,
  output logic [31:0] state_o
);

  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i)
      lfsr_d = SEED;
    else if (step_i)
      lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'h0);
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/mem_traffic_checker.sv
// Write-then-read-back traffic generator/checker for one memory-controller user port.
// Optional stall watchdog enabled by defining MEM_TC_TIMEOUT_EN.
// States: IDLE wait start | WR_REQ/RD_REQ command valid | WR_GAP/RD_GAP idle spacing | DONE finished
module mem_traffic_checker
  import mem_tc_pkg::*;
#(
  parameter int unsigned       DATA_W         = 256,
  parameter int unsigned       ADDR_W         = 28,
  parameter int unsigned       NUM_XFER       = 9,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = 28'h300_0000,
  parameter int unsigned       ADDR_STRIDE    = 8,
  parameter int unsigned       GAP_CYCLES     = 50,
  parameter logic [31:0]       SEED           = 32'hACE1_2468,
  parameter int unsigned       TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              loop_en,
  output logic [DATA_W-1:0] mem_data_wr,
  input  logic [DATA_W-1:0] mem_data_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [15:0]       pass_count
);

  localparam logic [15:0]       LAST_IDX = 16'(NUM_XFER - 1);
  localparam logic [31:0]       GAP_LOAD = 32'(GAP_CYCLES - 1);
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(ADDR_STRIDE);

  mem_tc_state_e     state_q, state_d;
  logic [15:0]       idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       gap_q, gap_d;
  logic              last_q, last_d;
  logic              loop_q, loop_d;
  logic              error_q, error_d;
  logic [15:0]       err_count_q, err_count_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [15:0]       pass_count_q, pass_count_d;

  logic              lfsr_load, lfsr_step;
  logic [31:0]       lfsr_state;
  logic [DATA_W-1:0] expect_data;
  logic              hs, miscompare, timeout, advance, fin, is_wr;

  mem_tc_lfsr32 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (lfsr_load),
    .step_i  (lfsr_step),
    .state_o (lfsr_state)
  );

  always_comb begin
    expect_data = '0;
    for (int k = 0; k < int'(DATA_W / 32); k++)
      expect_data[32*k +: 32] = lane_word(lfsr_state, k);
  end

  assign mem_valid  = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ);
  assign is_wr      = (state_q == ST_WR_REQ) || (state_q == ST_WR_GAP);
  assign hs         = mem_valid & mem_ready;
  assign miscompare = (mem_data_rd != expect_data);

`ifdef MEM_TC_TIMEOUT_EN
  logic [31:0] to_q;

  assign timeout = mem_valid && !mem_ready && (to_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !(mem_valid && !mem_ready)) to_q <= '0;
    else                                   to_q <= to_q + 32'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    gap_d        = gap_q;
    last_d       = last_q;
    loop_d       = loop_q;
    error_d      = error_q;
    err_count_d  = err_count_q;
    fail_addr_d  = fail_addr_q;
    pass_count_d = pass_count_q;
    lfsr_load    = 1'b0;
    lfsr_step    = 1'b0;
    advance      = 1'b0;
    fin          = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_WR_REQ;
          idx_d        = '0;
          addr_d       = BASE_ADDR;
          loop_d       = loop_en;
          error_d      = 1'b0;
          err_count_d  = '0;
          fail_addr_d  = '0;
          pass_count_d = '0;
          lfsr_load    = 1'b1;
        end
      end
      ST_WR_REQ, ST_RD_REQ: begin
        if (hs) begin
          lfsr_step = 1'b1;
          fin       = (idx_q == LAST_IDX);
          last_d    = fin;
          idx_d     = fin ? '0 : idx_q + 16'd1;
          addr_d    = fin ? BASE_ADDR : addr_q + STRIDE;
          if (!is_wr && miscompare) begin
            error_d = 1'b1;
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            if (err_count_q == 16'h0000) fail_addr_d = addr_q;
          end
          if (GAP_CYCLES == 0) begin
            advance = 1'b1;
          end else begin
            state_d = is_wr ? ST_WR_GAP : ST_RD_GAP;
            gap_d   = GAP_LOAD;
          end
        end
      end
      ST_WR_GAP, ST_RD_GAP: begin
        fin = last_q;
        if (gap_q == 32'd0) advance = 1'b1;
        else                gap_d   = gap_q - 32'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Leaving a transfer: continue the phase, switch phase, or close the pass.
    if (advance) begin
      if (!fin) begin
        state_d = is_wr ? ST_WR_REQ : ST_RD_REQ;
      end else if (is_wr) begin
        state_d   = ST_RD_REQ;
        lfsr_load = 1'b1;
      end else begin
        pass_count_d = pass_count_q + 16'd1;
        lfsr_load    = 1'b1;
        state_d      = loop_q ? ST_WR_REQ : ST_DONE;
      end
    end

    if (timeout) begin
      state_d = ST_DONE;
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      addr_q       <= '0;
      gap_q        <= '0;
      last_q       <= 1'b0;
      loop_q       <= 1'b0;
      error_q      <= 1'b0;
      err_count_q  <= '0;
      fail_addr_q  <= '0;
      pass_count_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      gap_q        <= gap_d;
      last_q       <= last_d;
      loop_q       <= loop_d;
      error_q      <= error_d;
      err_count_q  <= err_count_d;
      fail_addr_q  <= fail_addr_d;
      pass_count_q <= pass_count_d;
    end
  end

  assign mem_data_wr = (state_q == ST_WR_REQ) ? expect_data : '0;
  assign mem_addr    = addr_q;
  assign mem_rw      = is_wr;
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done        = (state_q == ST_DONE);
  assign error       = error_q;
  assign err_count   = err_count_q;
  assign fail_addr   = fail_addr_q;
  assign pass_count  = pass_count_q;

endmodule
